move_issuer_pika: RTL and testbench

Initiator-side turn sequencer for Pikachu's attacks. It accepts a one-hot move request from the player input path and enforces per-move PP limits. It drives the 3-bit move code and the five enable strobes of the opponent's damage block in the required order, and waits on that block's done/game-over feedback. It sits between the player input/turn FSM and the damage datapath.

---
 rtl/move_issuer_pika.sv | 207 ++++++++++++++++++++
 tb/tb_move_issuer_pika.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_issuer_pika.sv
// move_issuer_pika: initiator-side turn sequencer for Pikachu's attacks.
//
// Takes a one-hot move request from the player input path, enforces the
// per-move PP limits and walks the opponent's damage block through its
// enable strobes in a fixed order, waiting on that block's done feedback.
//
// Ports:
//   clock                     system clock, rising edge
//   reset                     asynchronous, active-high; clears all state
//   turn_en                   high while it is this player's turn
//   key_select[2:0]           001 quick attack, 010 thunderbolt, 100 volt tackle
//   done_decrement            level, decrement control finished
//   done_damage               level, white-draw unit finished
//   game_over                 opponent fainted (sampled in COMMIT)
//   move_out[2:0]             accepted move code, 000 when idle/over
//   enable_DMG_reg .. enable_draw_decrease   damage block strobes
//   pp_qa/pp_tb/pp_vt[3:0]    remaining PP per move
//   busy                      high outside IDLE/OVER
//   turn_done                 one-cycle pulse at the end of a completed turn
//   rejected                  one-cycle pulse when a move with PP = 0 is requested
//   timeout_err               sticky abort flag, cleared by the next accepted request
//   battle_over               high in OVER
//   state_dbg[2:0]            current FSM state, for observation
//
// Handshake: the damage block strobes are level requests; each strobe in
// DECR/DRAW stays high until the matching done level is sampled high on a
// rising clock edge, or until the wait budget expires.
module move_issuer_pika #(
  parameter int PP_QA   = 8,
  parameter int PP_TB   = 5,
  parameter int PP_VT   = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       turn_en,
  input  logic [2:0] key_select,
  input  logic       done_decrement,
  input  logic       done_damage,
  input  logic       game_over,
  output logic [2:0] move_out,
  output logic       enable_DMG_reg,
  output logic       enable_DMG_calc,
  output logic       enable_HP_calc,
  output logic       enable_decrement_control,
  output logic       enable_draw_decrease,
  output logic [3:0] pp_qa,
  output logic [3:0] pp_tb,
  output logic [3:0] pp_vt,
  output logic       busy,
  output logic       turn_done,
  output logic       rejected,
  output logic       timeout_err,
  output logic       battle_over,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_CALC, S_COMMIT, S_DECR, S_DRAW, S_FINISH, S_OVER
  } state_t;

  localparam logic [3:0] PP_QA_INIT = 4'(PP_QA);
  localparam logic [3:0] PP_TB_INIT = 4'(PP_TB);
  localparam logic [3:0] PP_VT_INIT = 4'(PP_VT);
  // Count value seen during the last allowed wait cycle; reaching it without
  // a done means TIMEOUT cycles have been spent in the wait state.
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [2:0] code;
  logic       armed;
  logic       over_pend;
  logic [9:0] tmo_cnt;

  logic       key_valid;
  logic [3:0] sel_pp;
  logic       accept, reject, abort;

  // PP of the requested move; key_valid only for exactly one-hot codes.
  always_comb begin
    key_valid = 1'b1;
    sel_pp    = 4'd0;
    case (key_select)
      3'b001:  sel_pp = pp_qa;
      3'b010:  sel_pp = pp_tb;
      3'b100:  sel_pp = pp_vt;
      default: key_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    abort    = 1'b0;
    case (state)
      S_IDLE: begin
        if (turn_en && armed && key_valid) begin
          if (sel_pp != 4'd0) begin
            accept   = 1'b1;
            state_nx = S_LATCH;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_LATCH:  state_nx = S_CALC;
      S_CALC:   state_nx = S_COMMIT;
      S_COMMIT: state_nx = S_DECR;
      S_DECR: begin
        if (done_decrement) begin
          state_nx = S_DRAW;
        end else if (tmo_cnt == TMO_LAST) begin
          abort    = 1'b1;
          state_nx = S_FINISH;
        end
      end
      S_DRAW: begin
        if (done_damage) begin
          state_nx = over_pend ? S_OVER : S_FINISH;
        end else if (tmo_cnt == TMO_LAST) begin
          abort    = 1'b1;
          state_nx = S_FINISH;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      S_OVER:   state_nx = S_OVER;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      code        <= 3'b000;
      pp_qa       <= PP_QA_INIT;
      pp_tb       <= PP_TB_INIT;
      pp_vt       <= PP_VT_INIT;
      armed       <= 1'b1;
      rejected    <= 1'b0;
      timeout_err <= 1'b0;
      over_pend   <= 1'b0;
      tmo_cnt     <= 10'd0;
    end else begin
      state    <= state_nx;
      rejected <= reject;

      // A held key fires once: re-arm only after the key is released.
      if (key_select == 3'b000) begin
        armed <= 1'b1;
      end else if (accept || reject) begin
        armed <= 1'b0;
      end

      // Acceptance only happens with PP > 0, so the counters never wrap.
      if (accept) begin
        code        <= key_select;
        timeout_err <= 1'b0;
        case (key_select)
          3'b001:  pp_qa <= pp_qa - 4'd1;
          3'b010:  pp_tb <= pp_tb - 4'd1;
          default: pp_vt <= pp_vt - 4'd1;
        endcase
      end else if (abort) begin
        timeout_err <= 1'b1;
      end

      if (state == S_COMMIT) begin
        over_pend <= game_over;
      end

      // Restart the wait budget on every state change (covers entry to
      // DECR and DRAW); count only while waiting.
      if (state_nx != state) begin
        tmo_cnt <= 10'd0;
      end else if (state == S_DECR || state == S_DRAW) begin
        tmo_cnt <= tmo_cnt + 10'd1;
      end
    end
  end

  // Moore outputs decoded purely from registered state.
  always_comb begin
    move_out                 = 3'b000;
    enable_DMG_reg           = 1'b0;
    enable_DMG_calc          = 1'b0;
    enable_HP_calc           = 1'b0;
    enable_decrement_control = 1'b0;
    enable_draw_decrease     = 1'b0;
    busy                     = 1'b0;
    turn_done                = 1'b0;
    battle_over              = 1'b0;
    case (state)
      S_LATCH:  begin move_out = code; busy = 1'b1; enable_DMG_reg           = 1'b1; end
      S_CALC:   begin move_out = code; busy = 1'b1; enable_DMG_calc          = 1'b1; end
      S_COMMIT: begin move_out = code; busy = 1'b1; enable_HP_calc           = 1'b1; end
      S_DECR:   begin move_out = code; busy = 1'b1; enable_decrement_control = 1'b1; end
      S_DRAW:   begin move_out = code; busy = 1'b1; enable_draw_decrease     = 1'b1; end
      S_FINISH: begin move_out = code; busy = 1'b1; turn_done                = 1'b1; end
      S_OVER:   battle_over = 1'b1;
      default:  ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_move_issuer_pika.sv
// Testbench for move_issuer_pika: directed key sequences, a reactive model
// of the damage block's done feedback, a turn-level schedule model checked
// every cycle, and literal expectations for the headline numbers.
module tb_move_issuer_pika;

  localparam int PP_QA   = 8;
  localparam int PP_TB   = 5;
  localparam int PP_VT   = 3;
  localparam int TIMEOUT = 1023;

  logic       clock, reset, turn_en, done_decrement, done_damage, game_over;
  logic [2:0] key_select, move_out, state_dbg;
  logic       enable_DMG_reg, enable_DMG_calc, enable_HP_calc;
  logic       enable_decrement_control, enable_draw_decrease;
  logic [3:0] pp_qa, pp_tb, pp_vt;
  logic       busy, turn_done, rejected, timeout_err, battle_over;

  move_issuer_pika #(.PP_QA(PP_QA), .PP_TB(PP_TB), .PP_VT(PP_VT), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .turn_en(turn_en), .key_select(key_select),
    .done_decrement(done_decrement), .done_damage(done_damage), .game_over(game_over),
    .move_out(move_out), .enable_DMG_reg(enable_DMG_reg), .enable_DMG_calc(enable_DMG_calc),
    .enable_HP_calc(enable_HP_calc), .enable_decrement_control(enable_decrement_control),
    .enable_draw_decrease(enable_draw_decrease), .pp_qa(pp_qa), .pp_tb(pp_tb), .pp_vt(pp_vt),
    .busy(busy), .turn_done(turn_done), .rejected(rejected), .timeout_err(timeout_err),
    .battle_over(battle_over), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- damage block feedback ----------------
  // done_* rises after the strobe has been high for *_delay cycles.
  int dec_delay = 0, dmg_delay = 0;
  int dec_seen = 0, dmg_seen = 0;
  always @(posedge clock) begin
    #1;
    if (enable_decrement_control) dec_seen++; else dec_seen = 0;
    if (enable_draw_decrease) dmg_seen++; else dmg_seen = 0;
    done_decrement = enable_decrement_control && (dec_seen > dec_delay);
    done_damage    = enable_draw_decrease && (dmg_seen > dmg_delay);
  end

  // ---------------- event counters ----------------
  int n_reg = 0, n_calc = 0, n_hp = 0, n_dec = 0, n_draw = 0, n_td = 0, n_rej = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (enable_DMG_reg) n_reg++;
      if (enable_DMG_calc) n_calc++;
      if (enable_HP_calc) n_hp++;
      if (enable_decrement_control) n_dec++;
      if (enable_draw_decrease) n_draw++;
      if (turn_done) n_td++;
      if (rejected) n_rej++;
    end
  end

  // ---------------- behavioural model / scoreboard ----------------
  // Each accepted request expands into the full list of per-cycle outputs
  // of its turn: {move[2:0], strobes{reg,calc,hp,dec,draw}, busy, turn_done, timeout_err}.
  localparam int EW = 11;
  logic [EW-1:0] exp_q[$];
  logic [3:0]    m_pp[3];
  logic          m_armed, m_rej, m_terr, m_over;

  function automatic logic [EW-1:0] mk(input logic [2:0] mv, input logic [4:0] stb,
                                       input logic bz, input logic td, input logic te);
    return {mv, stb, bz, td, te};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pp[0] = 4'(PP_QA); m_pp[1] = 4'(PP_TB); m_pp[2] = 4'(PP_VT);
    m_armed = 1'b1; m_rej = 1'b0; m_terr = 1'b0; m_over = 1'b0;
  endtask

  task automatic schedule_turn(input logic [2:0] c);
    int  dl, dr;
    logic tmo;
    tmo = 1'b0;
    exp_q.push_back(mk(c, 5'b10000, 1, 0, 0));
    exp_q.push_back(mk(c, 5'b01000, 1, 0, 0));
    exp_q.push_back(mk(c, 5'b00100, 1, 0, 0));
    dl = dec_delay + 1;
    if (dl > TIMEOUT) begin tmo = 1'b1; dl = TIMEOUT; end
    for (int i = 0; i < dl; i++) exp_q.push_back(mk(c, 5'b00010, 1, 0, 0));
    if (!tmo) begin
      dr = dmg_delay + 1;
      if (dr > TIMEOUT) begin tmo = 1'b1; dr = TIMEOUT; end
      for (int i = 0; i < dr; i++) exp_q.push_back(mk(c, 5'b00001, 1, 0, 0));
    end
    if (tmo || !game_over) exp_q.push_back(mk(c, 5'b00000, 1, 1, tmo));
    m_terr = tmo;
    if (!tmo && game_over) m_over = 1'b1;
  endtask

  always @(negedge clock) begin
    logic [EW-1:0] cur;
    logic          e_rej, e_bo, in_turn;
    int            idx;
    if (reset) model_reset();
    in_turn = (exp_q.size() != 0);
    cur   = in_turn ? exp_q[0] : mk(3'b000, 5'b00000, 0, 0, m_terr);
    e_rej = in_turn ? 1'b0 : m_rej;
    e_bo  = in_turn ? 1'b0 : m_over;
    chk("move_out", move_out, cur[10:8]);
    chk("strobes", {enable_DMG_reg, enable_DMG_calc, enable_HP_calc,
                    enable_decrement_control, enable_draw_decrease}, cur[7:3]);
    chk("status", {busy, turn_done, rejected, timeout_err, battle_over},
        {cur[2], cur[1], e_rej, cur[0], e_bo});
    chk("pp", {pp_qa, pp_tb, pp_vt}, {m_pp[0], m_pp[1], m_pp[2]});
    if (!reset) begin
      if (in_turn) void'(exp_q.pop_front());
      m_rej = 1'b0;
      if (!in_turn && !m_over && turn_en && m_armed &&
          (key_select == 3'b001 || key_select == 3'b010 || key_select == 3'b100)) begin
        idx = (key_select == 3'b001) ? 0 : (key_select == 3'b010) ? 1 : 2;
        if (m_pp[idx] != 4'd0) begin
          m_pp[idx] = m_pp[idx] - 4'd1;
          schedule_turn(key_select);
        end else begin
          m_rej = 1'b1;
        end
        m_armed = 1'b0;
      end
      if (key_select == 3'b000) m_armed = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input logic [2:0] k, input int hold);
    @(posedge clock); #1;
    key_select = k;
    repeat (hold) @(posedge clock);
    #1;
    key_select = 3'b000;
  endtask

  task automatic wait_idle();
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(negedge clock);
    end
    chk("wait_idle", busy, 0);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  int s_reg, s_calc, s_hp, s_dec, s_draw, s_td, s_rej;
  task automatic snap();
    s_reg = n_reg; s_calc = n_calc; s_hp = n_hp; s_dec = n_dec;
    s_draw = n_draw; s_td = n_td; s_rej = n_rej;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; turn_en = 1'b1; key_select = 3'b000; game_over = 1'b0;
    done_decrement = 1'b0; done_damage = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); #1;
    chk("reset_pp_qa", pp_qa, 8);
    chk("reset_busy", busy, 0);

    // Minimum turn: key 001 for one cycle, immediate dones.
    @(posedge clock); #1;
    key_select = 3'b001;
    snap();
    @(negedge clock);
    n = 0;
    @(posedge clock); #1 key_select = 3'b000;
    for (int i = 2; i <= 50; i++) begin
      @(negedge clock);
      if (turn_done) begin n = i; break; end
    end
    chk("turn_latency", n, 7);
    wait_idle();
    chk("reg_cycles", n_reg - s_reg, 1);
    chk("calc_cycles", n_calc - s_calc, 1);
    chk("hp_cycles", n_hp - s_hp, 1);
    chk("dec_cycles", n_dec - s_dec, 1);
    chk("draw_cycles", n_draw - s_draw, 1);
    chk("pp_qa_after1", pp_qa, 7);

    // turn_en low: request ignored.
    turn_en = 1'b0;
    press(3'b010, 1);
    repeat (4) @(negedge clock);
    #1;
    chk("no_turn_pp_tb", pp_tb, 5);
    chk("no_turn_busy", busy, 0);
    turn_en = 1'b1;

    // Held key fires once; PP exhaustion and rejection.
    snap();
    press(3'b100, 40);
    wait_idle();
    chk("held_turns", n_td - s_td, 1);
    chk("pp_vt_held", pp_vt, 2);
    press(3'b100, 1); wait_idle();
    press(3'b100, 1); wait_idle();
    chk("pp_vt_empty", pp_vt, 0);
    snap();
    press(3'b100, 1); wait_idle();
    chk("reject_pulses", n_rej - s_rej, 1);
    chk("reject_pp_vt", pp_vt, 0);
    chk("reject_no_turn", n_td - s_td, 0);

    // Slow damage block; turn_en dropped mid-turn has no effect.
    dec_delay = 20; dmg_delay = 5;
    snap();
    press(3'b010, 1);
    repeat (5) @(posedge clock);
    #1 turn_en = 1'b0;
    wait_idle();
    turn_en = 1'b1;
    chk("slow_dec_cycles", n_dec - s_dec, 21);
    chk("slow_draw_cycles", n_draw - s_draw, 6);
    chk("slow_turn_done", n_td - s_td, 1);
    chk("pp_tb_after", pp_tb, 4);

    // Decrement never completes: abort after TIMEOUT cycles.
    dec_delay = 100000; dmg_delay = 0;
    snap();
    press(3'b001, 1);
    wait_idle();
    chk("tmo_dec_cycles", n_dec - s_dec, 1023);
    chk("tmo_draw_cycles", n_draw - s_draw, 0);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_turn_done", n_td - s_td, 1);
    dec_delay = 0;
    press(3'b001, 1);
    wait_idle();
    chk("tmo_err_cleared", timeout_err, 0);
    chk("pp_qa_after_tmo", pp_qa, 5);

    // Opponent faints: turn completes into OVER, then requests ignored.
    game_over = 1'b1;
    snap();
    press(3'b010, 1);
    wait_idle();
    chk("over_flag", battle_over, 1);
    chk("over_no_turn_done", n_td - s_td, 0);
    chk("over_draw_cycles", n_draw - s_draw, 1);
    game_over = 1'b0;
    press(3'b001, 1);
    repeat (4) @(negedge clock);
    #1;
    chk("over_ignores_pp", pp_qa, 5);
    chk("over_busy", busy, 0);

    pulse_reset();
    @(negedge clock); #1;
    chk("rst_pp_qa", pp_qa, 8);
    chk("rst_pp_tb", pp_tb, 5);
    chk("rst_pp_vt", pp_vt, 3);
    chk("rst_over", battle_over, 0);

    // Asynchronous reset while waiting in DRAW.
    dmg_delay = 50;
    press(3'b100, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (enable_draw_decrease) break;
    end
    chk("reach_draw", enable_draw_decrease, 1);
    @(posedge clock); #3 reset = 1'b1;
    #1;
    chk("async_move_out", move_out, 0);
    chk("async_strobes", {enable_DMG_reg, enable_DMG_calc, enable_HP_calc,
                          enable_decrement_control, enable_draw_decrease}, 0);
    chk("async_busy", busy, 0);
    chk("async_pp_vt", pp_vt, 3);
    @(posedge clock); #1 reset = 1'b0;
    dmg_delay = 0;

    // Multi-hot codes are ignored.
    snap();
    press(3'b011, 1);
    repeat (3) @(negedge clock);
    press(3'b110, 1);
    repeat (4) @(negedge clock);
    #1;
    chk("multihot_busy", busy, 0);
    chk("multihot_pp", {pp_qa, pp_tb, pp_vt}, {4'd8, 4'd5, 4'd3});
    chk("multihot_rej", n_rej - s_rej, 0);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
